// File: rtl/usb_regfile_v2.sv
// usb_regfile_v2: SNES-visible USB register window with an ID string, MCU-driven
// STATUS, SNES CTRL and a SNES->MCU byte FIFO mailbox with an MCU interrupt.
// Optional macro USB_STATUS_W1C_EN: SNES writes to addr 0 clear STATUS bits (W1C).
module usb_regfile_v2 #(
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned FIFO_AW    = 4,
    parameter logic [47:0] ID_STR     = 48'h532D55534232,
    parameter int unsigned IRQ_THRESH = 1
) (
    input  logic                 clkin,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [ADDR_W-1:0]    reg_addr,
    input  logic [7:0]           reg_data_in,
    output logic [7:0]           reg_data_out,
    input  logic                 reg_oe_falling,
    input  logic                 reg_oe_rising,
    input  logic                 reg_we_rising,
    input  logic [7:0]           status_set_bits,
    input  logic [7:0]           status_reset_bits,
    input  logic                 status_reset_we,
    input  logic                 mcu_pop,
    output logic [7:0]           mcu_data,
    output logic                 mcu_empty,
    output logic [FIFO_AW:0]     mcu_level,
    output logic                 mcu_irq
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned LVL_W = FIFO_AW + 1;

    localparam logic [ADDR_W-1:0] A_STATUS   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_CTRL     = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_TXDATA   = ADDR_W'(8);
    localparam logic [ADDR_W-1:0] A_FIFOSTAT = ADDR_W'(9);

    logic [7:0]         r_status;
    logic [7:0]         r_ctrl;
    logic [1:0]         r_hist;
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [LVL_W-1:0]   r_level;
    logic               r_ovf;
    logic [7:0]         r_rdata;
    logic               r_irq;
    logic [7:0]         r_mcu_data;
    logic               r_empty;
    logic [7:0]         r_mem [DEPTH];

    logic               w_wr;
    logic               w_rd;
    logic               w_full;
    logic               w_push_req;
    logic               w_pop;
    logic               w_push;
    logic               w_new_ovf;
    logic               w_ovf_clr;
    logic               w_ovf_next;
    logic               w_status_fire;
    logic [7:0]         w_w1c;
    logic [7:0]         w_status_next;
    logic [7:0]         w_ctrl_next;
    logic [FIFO_AW-1:0] w_wr_ptr_next;
    logic [FIFO_AW-1:0] w_rd_ptr_next;
    logic [LVL_W-1:0]   w_level_next;
    logic [7:0]         w_head_next;
    logic               w_irq_next;
    logic [7:0]         w_rd_data;
    logic               w_unused;

    // The reserved read-rising strobe has no function in this block.
    assign w_unused = reg_oe_rising;

    assign w_wr       = enable & reg_we_rising;
    assign w_rd       = enable & reg_oe_falling;
    assign w_full     = (r_level == LVL_W'(DEPTH));
    assign w_push_req = w_wr & (reg_addr == A_TXDATA);
    assign w_pop      = mcu_pop & ~r_empty;
    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_new_ovf  = w_push_req & w_full & ~w_pop;
    assign w_ovf_clr  = w_wr & (reg_addr == A_FIFOSTAT) & reg_data_in[5];
    // A fresh overflow wins over a coincident clear.
    assign w_ovf_next = (r_ovf & ~w_ovf_clr) | w_new_ovf;
    assign w_ctrl_next = (w_wr && (reg_addr == A_CTRL)) ? reg_data_in : r_ctrl;

    assign w_status_fire = (r_hist == 2'b01);

`ifdef USB_STATUS_W1C_EN
    assign w_w1c = (w_wr && (reg_addr == A_STATUS)) ? reg_data_in : 8'h00;
`else
    assign w_w1c = 8'h00;
`endif

    // STATUS next value: MCU edge update (reset wins) merged with SNES W1C.
    always_comb begin
        w_status_next = r_status;
        if (w_status_fire) begin
            w_status_next = (r_status | status_set_bits) & ~status_reset_bits;
        end
        w_status_next = w_status_next & ~w_w1c;
    end

    // FIFO pointer/level next values and the show-ahead head for the next cycle.
    always_comb begin
        w_wr_ptr_next = w_push ? (r_wr_ptr + FIFO_AW'(1)) : r_wr_ptr;
        w_rd_ptr_next = w_pop  ? (r_rd_ptr + FIFO_AW'(1)) : r_rd_ptr;
        w_level_next  = r_level;
        if (w_push && !w_pop) begin
            w_level_next = r_level + LVL_W'(1);
        end else if (!w_push && w_pop) begin
            w_level_next = r_level - LVL_W'(1);
        end
        w_head_next = 8'h00;
        if (w_level_next != LVL_W'(0)) begin
            // The byte being pushed becomes the head when it lands at the new read slot.
            if (w_push && (w_rd_ptr_next == r_wr_ptr)) begin
                w_head_next = reg_data_in;
            end else begin
                w_head_next = r_mem[w_rd_ptr_next];
            end
        end
        w_irq_next = (w_level_next >= LVL_W'(IRQ_THRESH)) | w_ovf_next | w_ctrl_next[0];
    end

    // Register read mux; reflects state before this cycle's updates.
    always_comb begin
        w_rd_data = 8'h00;
        case (reg_addr)
            A_STATUS:    w_rd_data = r_status;
            A_CTRL:      w_rd_data = r_ctrl;
            ADDR_W'(2):  w_rd_data = ID_STR[47:40];
            ADDR_W'(3):  w_rd_data = ID_STR[39:32];
            ADDR_W'(4):  w_rd_data = ID_STR[31:24];
            ADDR_W'(5):  w_rd_data = ID_STR[23:16];
            ADDR_W'(6):  w_rd_data = ID_STR[15:8];
            ADDR_W'(7):  w_rd_data = ID_STR[7:0];
            A_FIFOSTAT:  w_rd_data = {w_full, r_empty, r_ovf, 5'(r_level)};
            default:     w_rd_data = 8'h00;
        endcase
    end

    // FIFO storage; contents are don't-care once the pointers are reset.
    always_ff @(posedge clkin) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= reg_data_in;
        end
    end

    // Control/status state, FIFO bookkeeping and registered outputs.
    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            r_status   <= 8'h00;
            r_ctrl     <= 8'h00;
            r_hist     <= 2'b00;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_ovf      <= 1'b0;
            r_rdata    <= 8'h00;
            r_irq      <= 1'b0;
            r_mcu_data <= 8'h00;
            r_empty    <= 1'b1;
        end else begin
            r_status   <= w_status_next;
            r_ctrl     <= w_ctrl_next;
            r_hist     <= {r_hist[0], status_reset_we};
            r_wr_ptr   <= w_wr_ptr_next;
            r_rd_ptr   <= w_rd_ptr_next;
            r_level    <= w_level_next;
            r_ovf      <= w_ovf_next;
            r_irq      <= w_irq_next;
            r_mcu_data <= w_head_next;
            r_empty    <= (w_level_next == LVL_W'(0));
            if (w_rd) begin
                r_rdata <= w_rd_data;
            end
        end
    end

    assign reg_data_out = r_rdata;
    assign mcu_data     = r_mcu_data;
    assign mcu_empty    = r_empty;
    assign mcu_level    = r_level;
    assign mcu_irq      = r_irq;

endmodule

// File: tb/tb_usb_regfile_v2.sv
// Bench for usb_regfile_v2: queue-based reference model compared every cycle,
// plus directed sequences with hand-computed literal expectations.
module tb_usb_regfile_v2;

    localparam int DEPTH  = 16;
    localparam int THRESH = 1;
    localparam logic [47:0] ID = 48'h532D55534232;

    logic       clkin = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [3:0] reg_addr;
    logic [7:0] reg_data_in;
    logic [7:0] reg_data_out;
    logic       reg_oe_falling;
    logic       reg_oe_rising;
    logic       reg_we_rising;
    logic [7:0] status_set_bits;
    logic [7:0] status_reset_bits;
    logic       status_reset_we;
    logic       mcu_pop;
    logic [7:0] mcu_data;
    logic       mcu_empty;
    logic [4:0] mcu_level;
    logic       mcu_irq;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    usb_regfile_v2 dut (
        .clkin(clkin), .rst_n(rst_n), .enable(enable), .reg_addr(reg_addr),
        .reg_data_in(reg_data_in), .reg_data_out(reg_data_out),
        .reg_oe_falling(reg_oe_falling), .reg_oe_rising(reg_oe_rising),
        .reg_we_rising(reg_we_rising), .status_set_bits(status_set_bits),
        .status_reset_bits(status_reset_bits), .status_reset_we(status_reset_we),
        .mcu_pop(mcu_pop), .mcu_data(mcu_data), .mcu_empty(mcu_empty),
        .mcu_level(mcu_level), .mcu_irq(mcu_irq)
    );

    always #5 clkin = ~clkin;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference model state
    byte unsigned q[$];
    logic [7:0] m_status = 8'h00, m_ctrl = 8'h00, m_rdata = 8'h00;
    bit         m_ovf = 1'b0, m_irq = 1'b0;
    bit         m_we_last = 1'b0, m_we_prev = 1'b0;

    function automatic logic [7:0] m_read(input logic [3:0] a);
        logic [47:0] id;
        id = ID;
        case (a)
            4'd0: return m_status;
            4'd1: return m_ctrl;
            4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: return id[8*(7-int'(a)) +: 8];
            4'd9: return {(q.size() == DEPTH), (q.size() == 0), m_ovf, 5'(q.size())};
            default: return 8'h00;
        endcase
    endfunction

    // Model update on each clock edge from the same inputs the DUT sees.
    always @(posedge clkin) begin
        if (!rst_n) begin
            q.delete();
            m_status = 8'h00; m_ctrl = 8'h00; m_rdata = 8'h00;
            m_ovf = 1'b0; m_irq = 1'b0; m_we_last = 1'b0; m_we_prev = 1'b0;
        end else begin
            bit wr, push, pop, accept, clr, over;
            wr   = enable && reg_we_rising;
            push = wr && reg_addr == 4'd8;
            pop  = mcu_pop && q.size() > 0;
            if (enable && reg_oe_falling) m_rdata = m_read(reg_addr);
            if (m_we_last && !m_we_prev)
                m_status = (m_status | status_set_bits) & ~status_reset_bits;
`ifdef USB_STATUS_W1C_EN
            if (wr && reg_addr == 4'd0) m_status = m_status & ~reg_data_in;
`endif
            if (wr && reg_addr == 4'd1) m_ctrl = reg_data_in;
            accept = push && (q.size() < DEPTH || pop);
            over   = push && !accept;
            clr    = wr && reg_addr == 4'd9 && reg_data_in[5];
            if (pop) void'(q.pop_front());
            if (accept) q.push_back(reg_data_in);
            m_ovf = (m_ovf && !clr) || over;
            m_irq = (q.size() >= THRESH) || m_ovf || m_ctrl[0];
            m_we_prev = m_we_last;
            m_we_last = status_reset_we;
        end
    end

    // Every-cycle comparison of all DUT outputs against the model.
    always @(negedge clkin) begin
        if (chk_en) begin
            chk("rdata",  32'(reg_data_out), 32'(m_rdata));
            chk("mdata",  32'(mcu_data),     32'(q.size() > 0 ? q[0] : 8'h00));
            chk("empty",  32'(mcu_empty),    32'(q.size() == 0));
            chk("level",  32'(mcu_level),    32'(q.size()));
            chk("irq",    32'(mcu_irq),      32'(m_irq));
        end
    end

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        enable = 1'b1; reg_addr = a; reg_data_in = d; reg_we_rising = 1'b1;
        @(negedge clkin);
        reg_we_rising = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [7:0] exp, input string name);
        enable = 1'b1; reg_addr = a; reg_oe_falling = 1'b1;
        @(negedge clkin);
        reg_oe_falling = 1'b0;
        chk(name, 32'(reg_data_out), 32'(exp));
    endtask

    task automatic pop1();
        mcu_pop = 1'b1;
        @(negedge clkin);
        mcu_pop = 1'b0;
    endtask

    task automatic mcu_req(input logic [7:0] s, input logic [7:0] r);
        status_set_bits = s; status_reset_bits = r; status_reset_we = 1'b1;
        repeat (10) @(negedge clkin);
        status_reset_we = 1'b0;
        repeat (3) @(negedge clkin);
    endtask

    logic [7:0] id_exp [6];

    initial begin
        id_exp = '{8'h53, 8'h2D, 8'h55, 8'h53, 8'h42, 8'h32};
        rst_n = 1'b0; enable = 1'b0; reg_addr = 4'd0; reg_data_in = 8'h00;
        reg_oe_falling = 1'b0; reg_oe_rising = 1'b0; reg_we_rising = 1'b0;
        status_set_bits = 8'h00; status_reset_bits = 8'h00; status_reset_we = 1'b0;
        mcu_pop = 1'b0;
        @(negedge clkin);
        chk_en = 1'b1;
        chk("rst_empty", 32'(mcu_empty), 32'd1);
        chk("rst_rdata", 32'(reg_data_out), 32'd0);
        chk("rst_irq",   32'(mcu_irq), 32'd0);
        @(negedge clkin);
        rst_n = 1'b1;
        @(negedge clkin);

        // ID string, STATUS, unmapped
        for (int i = 0; i < 6; i++) rd(4'(i + 2), id_exp[i], "id");
        rd(4'd0, 8'h00, "status_rst");
        rd(4'd12, 8'h00, "unmapped");
        rd(4'd7, 8'h32, "id7");
        enable = 1'b0; reg_addr = 4'd2; reg_oe_falling = 1'b1;
        @(negedge clkin);
        reg_oe_falling = 1'b0;
        chk("rd_disabled_hold", 32'(reg_data_out), 32'h32);

        // MCU status updates
        mcu_req(8'h81, 8'h00);
        rd(4'd0, 8'h81, "status_set");
        mcu_req(8'h00, 8'h01);
        rd(4'd0, 8'h80, "status_clr");
        mcu_req(8'h02, 8'h02);
        rd(4'd0, 8'h80, "status_reset_wins");

        // Basic FIFO
        wr(4'd8, 8'hA5);
        wr(4'd8, 8'h5A);
        rd(4'd9, 8'h02, "fstat2");
        chk("head_a5", 32'(mcu_data), 32'hA5);
        chk("irq_lvl", 32'(mcu_irq), 32'd1);
        pop1();
        chk("head_5a", 32'(mcu_data), 32'h5A);
        pop1();
        chk("empty_after", 32'(mcu_empty), 32'd1);
        rd(4'd9, 8'h40, "fstat_empty");
        chk("irq_off", 32'(mcu_irq), 32'd0);
        pop1();
        chk("pop_empty_lvl", 32'(mcu_level), 32'd0);

        // CTRL doorbell, disabled write ignored
        wr(4'd1, 8'h01);
        chk("doorbell", 32'(mcu_irq), 32'd1);
        wr(4'd1, 8'h00);
        enable = 1'b0; reg_addr = 4'd1; reg_data_in = 8'h55; reg_we_rising = 1'b1;
        @(negedge clkin);
        reg_we_rising = 1'b0;
        rd(4'd1, 8'h00, "ctrl_disabled");

        // Fill, overflow, clear
        for (int i = 0; i < 16; i++) wr(4'd8, 8'(8'h10 + i));
        wr(4'd8, 8'hEE);
        rd(4'd9, 8'hB0, "fstat_ovf");
        wr(4'd9, 8'h20);
        rd(4'd9, 8'h90, "fstat_clr");

        // Push + pop while full
        enable = 1'b1; reg_addr = 4'd8; reg_data_in = 8'h11; reg_we_rising = 1'b1; mcu_pop = 1'b1;
        @(negedge clkin);
        reg_we_rising = 1'b0; mcu_pop = 1'b0;
        rd(4'd9, 8'h90, "fstat_pushpop");
        chk("head_after_pp", 32'(mcu_data), 32'h11);
        for (int i = 0; i < 15; i++) pop1();
        chk("last_11", 32'(mcu_data), 32'h11);
        chk("last_lvl", 32'(mcu_level), 32'd1);
        pop1();

        // W1C merged with MCU update
        mcu_req(8'hFF, 8'h00);
        rd(4'd0, 8'hFF, "status_ff");
        status_set_bits = 8'h00; status_reset_bits = 8'h80; status_reset_we = 1'b1;
        @(negedge clkin);
        wr(4'd0, 8'h0F);
        status_reset_we = 1'b0;
        repeat (2) @(negedge clkin);
`ifdef USB_STATUS_W1C_EN
        rd(4'd0, 8'h70, "status_w1c");
`else
        rd(4'd0, 8'h7F, "status_no_w1c");
`endif

        // Reset mid-transfer
        wr(4'd8, 8'h33);
        wr(4'd8, 8'h44);
        rst_n = 1'b0;
        @(negedge clkin);
        rst_n = 1'b1;
        chk("rst_mid_empty", 32'(mcu_empty), 32'd1);
        chk("rst_mid_lvl",   32'(mcu_level), 32'd0);
        chk("rst_mid_data",  32'(mcu_data),  32'd0);
        rd(4'd0, 8'h00, "rst_mid_status");

        repeat (2) @(negedge clkin);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
